m_axi_read_arbiter: RTL

//   Round-robin arbiter sharing one AXI4-Lite master read port (to the DMA register file) among
//   NUM_REQ sequencer-side requesters. Issues one read transaction at a time, routes RDATA/RRESP

---
 rtl/m_axi_read_arbiter.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/m_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : m_axi_read_arbiter
// Description : Round-robin arbiter that shares a single AXI4-Lite read master
//               port among NUM_REQ sequencer-side requesters. Only one read
//               is in flight at a time. The read data and response are routed
//               back to the requester that was granted.
//
// Ports
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   req_valid[i]      : read request from requester i
//   req_addr          : packed addresses, requester i at [i*AW +: AW]
//   req_ready         : one-hot accept pulse (combinational, IDLE only)
//   rsp_valid         : one-hot response pulse (registered)
//   rsp_data/rsp_resp : shared response payload, held until the next response
//   busy              : high whenever the FSM is not IDLE
//   prof_busy_cnt     : saturating busy-cycle counter (profiling build only)
//   M_AXI_*           : AXI4-Lite read address / read data channels
//
// Build option
//   M_AXI_READ_ARB_PROFILE_EN : when defined, prof_busy_cnt counts cycles
//                               spent outside IDLE and saturates at all-ones.
//                               When undefined, prof_busy_cnt is tied to 0.
//
// Revision    : 1.0 - initial release
// ============================================================================
module m_axi_read_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int IDX_WIDTH       = 2,
  parameter int GLOB_ADDR_WIDTH = 32,
  parameter int GLOB_DATA_WIDTH = 32,
  parameter int PROF_WIDTH      = 32
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_REQ-1:0]                   req_valid,
  input  logic [NUM_REQ*GLOB_ADDR_WIDTH-1:0]   req_addr,
  output logic [NUM_REQ-1:0]                   req_ready,
  output logic [NUM_REQ-1:0]                   rsp_valid,
  output logic [GLOB_DATA_WIDTH-1:0]           rsp_data,
  output logic [1:0]                           rsp_resp,
  output logic                                 busy,
  output logic [PROF_WIDTH-1:0]                prof_busy_cnt,
  output logic [GLOB_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic                                 M_AXI_ARVALID,
  input  logic                                 M_AXI_ARREADY,
  input  logic [GLOB_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                           M_AXI_RRESP,
  input  logic                                 M_AXI_RVALID,
  output logic                                 M_AXI_RREADY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [IDX_WIDTH-1:0]         ptr_q, ptr_d;
  logic [IDX_WIDTH-1:0]         gnt_q, gnt_d;
  logic [GLOB_ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic [GLOB_DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [1:0]                   rsp_resp_q, rsp_resp_d;
  logic [NUM_REQ-1:0]           rsp_valid_q, rsp_valid_d;

  logic                         sel_found;
  logic [IDX_WIDTH-1:0]         sel_idx;
  logic [IDX_WIDTH-1:0]         cand;

  // Round-robin pick: scan ptr+1, ptr+2, ... (mod NUM_REQ) and take the
  // first active request. ptr holds the last granted index, so the previous
  // winner is examined last and therefore has the lowest priority.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IDX_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      if (!sel_found && req_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    araddr_d    = araddr_q;
    rsp_data_d  = rsp_data_q;
    rsp_resp_d  = rsp_resp_q;
    rsp_valid_d = '0;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (sel_found) begin
          req_ready[sel_idx] = 1'b1;
          araddr_d = req_addr[int'(sel_idx)*GLOB_ADDR_WIDTH +: GLOB_ADDR_WIDTH];
          gnt_d    = sel_idx;
          ptr_d    = sel_idx;
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (M_AXI_ARREADY) begin
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_data_d         = M_AXI_RDATA;
          rsp_resp_d         = M_AXI_RRESP;
          rsp_valid_d[gnt_q] = 1'b1;
          state_d            = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register. Reset abandons any transfer in progress; clearing
  // rsp_valid here guarantees a beat coinciding with reset is never reported.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= IDX_WIDTH'(NUM_REQ - 1);
      gnt_q       <= '0;
      araddr_q    <= '0;
      rsp_data_q  <= '0;
      rsp_resp_q  <= '0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      araddr_q    <= araddr_d;
      rsp_data_q  <= rsp_data_d;
      rsp_resp_q  <= rsp_resp_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign M_AXI_ARADDR  = araddr_q;
  assign M_AXI_ARVALID = (state_q == ST_ADDR);
  assign M_AXI_RREADY  = (state_q == ST_DATA);
  assign busy          = (state_q != ST_IDLE);
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_resp      = rsp_resp_q;

`ifdef M_AXI_READ_ARB_PROFILE_EN
  logic [PROF_WIDTH-1:0] prof_cnt_q;

  // Saturating busy-cycle counter; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prof_cnt_q <= '0;
    end else if ((state_q != ST_IDLE) && (prof_cnt_q != {PROF_WIDTH{1'b1}})) begin
      prof_cnt_q <= prof_cnt_q + PROF_WIDTH'(1);
    end
  end

  assign prof_busy_cnt = prof_cnt_q;
`else
  assign prof_busy_cnt = '0;
`endif

endmodule
`default_nettype wire
